// File: rtl/left_rotate_seq_if.sv
// Command/status bundle between a controller and the left-rotate sequencer.
// The controller owns the master side; the sequencer is the slave.
interface left_rotate_seq_if #(
   parameter int DW = 4,
   parameter int CW = 2
);
   logic          load;
   logic [DW-1:0] data;
   logic          start;
   logic [CW-1:0] steps;
   logic          restore;
   logic [DW-1:0] q;
   logic          busy;
   logic          done;
   logic [CW-1:0] offset;

   modport master (
      output load, data, start, steps, restore,
      input  q, busy, done, offset
   );

   modport slave (
      input  load, data, start, steps, restore,
      output q, busy, done, offset
   );
endinterface

// File: rtl/left_rotate_seq.sv
// Left-rotate sequencer: loads a word, rotates it left one bit per clock on request,
// and tracks the cumulative offset so the original word can be restored.
module left_rotate_seq #(
   parameter int DW = 4,
   parameter int CW = 2
) (
   input  logic                clk,
   input  logic                sync_rst,
   left_rotate_seq_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROT  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] q_q, q_d;
   logic [CW-1:0] offset_q, offset_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      offset_d    = offset_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.load) begin
               q_d      = bus.data;
               offset_d = {CW{1'b0}};
            end else if (bus.start) begin
               if (bus.steps == {CW{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  remaining_d = bus.steps;
                  state_d     = ST_ROT;
               end
            end else if (bus.restore) begin
               // DW == 2**CW, so the CW-bit negation is (DW - offset) mod DW.
               remaining_d = {CW{1'b0}} - offset_q;
               if (offset_q == {CW{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ROT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ROT: begin
            q_d         = {q_q[DW-2:0], q_q[DW-1]};
            offset_d    = offset_q + CW'(1'b1);
            remaining_d = remaining_q - CW'(1'b1);
            if (remaining_q == CW'(1'b1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ROT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_ROT);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q     <= ST_IDLE;
         q_q         <= {DW{1'b0}};
         offset_q    <= {CW{1'b0}};
         remaining_q <= {CW{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         offset_q    <= offset_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.q      = q_q;
   assign bus.offset = offset_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: doc/left_rotate_seq.md
Name: left_rotate_seq

Overview:
- Left-rotate sequencer; the opposite direction of the team's right-rotate register.
- Parallel-loads a DW-bit word, then rotates it left a requested number of steps, one bit position per clock, under a start/busy/done handshake.
- Tracks the cumulative rotation offset since the last load and can restore the original word by completing the rotation modulo DW.
- Sits beside the right-rotate register in the datapath to undo or pre-compensate rotations.

Parameters:
DW, 4, data width; must equal 2**CW
CW, 2, width of steps and offset fields

Ports:
clk  input  1  rising-edge clock
sync_rst  input  1  synchronous active-high reset
load  input  1  parallel load request (honoured in IDLE only)
data  input  DW  load value
start  input  1  rotate-by-steps request (honoured in IDLE only)
steps  input  CW  number of left-rotate steps, 0..DW-1
restore  input  1  rotate left until offset returns to 0 (honoured in IDLE only)
q  output  DW  register contents
busy  output  1  high while in ROT
done  output  1  one-cycle completion pulse
offset  output  CW  cumulative left rotations mod DW since last load/reset

Behaviour:
- Reset is synchronous and active-high: a rising clk edge with sync_rst=1 sets q=0, offset=0, busy=0, done=0, remaining=0, state=IDLE.
  - Overrides every other input in every state, including mid-ROT.
  - An sync_rst pulse that does not span a rising edge has no effect.
- All outputs are registered. State machine: IDLE, ROT, DONE.
- IDLE: priority is load > start > restore; at most one command is accepted per edge.
  - load: q<=data, offset<=0; stays in IDLE; no done pulse.
  - start, steps=k: if k==0, go to DONE with q unchanged; else remaining<=k, go to ROT. q is unchanged on this capture edge.
  - restore: remaining<=(DW-offset) mod DW; if offset==0, go to DONE directly; else go to ROT.
- ROT (busy=1): each edge does:
  - q<={q[DW-2:0],q[DW-1]}
  - offset<=offset+1 (wraps DW-1 -> 0)
  - remaining<=remaining-1
  - On the edge where remaining==1, go to DONE.
  - load, start and restore are ignored throughout ROT.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE. Commands are ignored in DONE.
- Latency: command captured at edge E0; a k-step rotation completes at edge E0+k; done is high for the cycle after E0+k; IDLE is re-entered at E0+k+1. busy is high for exactly k cycles.
- A zero-step start, or a restore with offset==0: busy never rises, done pulses after E0, q is unchanged.
- Restore after any sequence of starts returns q to the last loaded word with offset=0.
- steps width limits a single rotation to DW-1 positions; a full-circle rotation is not requestable and needs no special handling.

Test Plan:
1. Reset: hold sync_rst=1 across 2 edges -> q=0, offset=0, busy=0, done=0. Pulse sync_rst from 2ns to 4ns of a 10ns cycle (no edge) -> no state change.
2. load data=4'b1001, then start steps=1 -> q=4'b0011, offset=1; busy high 1 cycle; done high exactly 1 cycle; back to IDLE.
3. load 4'b1000, start steps=3 -> q=0001, 0010, 0100 on successive edges, offset=3; then restore -> one rotation, q=1000, offset=0, done pulse.
4. start steps=0, and restore with offset=0 -> busy stays 0, done pulses 1 cycle after capture, q unchanged.
5. During ROT: assert load=1 data=4'b1111 and start -> ignored, rotation completes normally. Assert sync_rst mid-ROT -> next edge q=0, offset=0, busy=0, IDLE, no done.
6. Same edge: load=1 data=4'b0110 with start=1 steps=2 -> load wins; q=0110, offset=0, no busy/done. Offset wrap check: start steps=3, then start steps=2 -> offset=1, q is the load value rotated left 5 (equivalent to 1).
